// File: rtl/dot_mac_pkg.sv
// Shared types and default sizing for the dot_mac streaming multiply-accumulate block.
package dot_mac_pkg;

    localparam int unsigned DEF_N   = 5;
    localparam int unsigned DEF_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH,
        ST_DONE
    } dot_mac_state_t;

endpackage

// File: rtl/multiplier.sv
// Combinational unsigned array multiplier: p = a * b, built from shifted partial products.
module multiplier #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (b[i]) begin
                p = p + ((2*N)'(a) << i);
            end
        end
    end

endmodule

// File: rtl/dot_mac.sv
// Streaming dot-product MAC: accumulates x*y beats until in_last or LEN terms, then presents the sum.
// Build option DOT_MAC_PIPE_EN registers the product ahead of the adder (one extra cycle of latency).
module dot_mac
    import dot_mac_pkg::*;
#(
    parameter  int unsigned N      = DEF_N,
    parameter  int unsigned LEN    = DEF_LEN,
    localparam int unsigned PROD_W = 2 * N,
    localparam int unsigned ACC_W  = 2 * N + $clog2(LEN),
    localparam int unsigned CNT_W  = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_cnt
);

    logic [PROD_W-1:0] prod;
    multiplier #(.N(N)) u_mul (.a(x), .b(y), .p(prod));

    dot_mac_state_t    state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              out_valid_q, out_valid_d;
    logic              accept, term;
    logic [PROD_W-1:0] add_in;
    logic              add_en, add_first, flush_done;
    dot_mac_state_t    term_state;

    // Ready is a decode of the state register, held low for the whole reset pulse.
    assign in_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
    assign accept   = in_valid & in_ready;
    assign cnt_inc  = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign term     = in_last | (cnt_inc == CNT_W'(LEN));

`ifdef DOT_MAC_PIPE_EN
    logic [PROD_W-1:0] p_q;
    logic              p_valid_q, p_first_q, p_term_q;

    // Product stage: the adder consumes the previous beat's product one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q       <= '0;
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
            p_term_q  <= 1'b0;
        end else begin
            p_q       <= prod;
            p_valid_q <= accept;
            p_first_q <= (state_q == ST_IDLE);
            p_term_q  <= accept & term;
        end
    end

    assign add_in     = p_q;
    assign add_en     = p_valid_q;
    assign add_first  = p_first_q;
    assign flush_done = p_term_q;
    assign term_state = ST_FLUSH;
`else
    assign add_in     = prod;
    assign add_en     = accept;
    assign add_first  = (state_q == ST_IDLE);
    assign flush_done = 1'b0;
    assign term_state = ST_DONE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state and datapath; the first product of a sum loads rather than adds.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        if (add_en) begin
            acc_d = add_first ? ACC_W'(add_in) : acc_q + ACC_W'(add_in);
        end
        if (accept) begin
            cnt_d = cnt_inc;
        end
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    state_d = term ? term_state : ST_ACCUM;
                end
            end
            ST_FLUSH: begin
                if (flush_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_DONE);
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_dot_mac.sv
// Directed self-checking bench for dot_mac (N=5, LEN=4); honours DOT_MAC_PIPE_EN for latency.
module tb_dot_mac;

    localparam int unsigned N     = 5;
    localparam int unsigned LEN   = 4;
    localparam int unsigned ACC_W = 12;
    localparam int unsigned CNT_W = 3;
`ifdef DOT_MAC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     x = '0;
    logic [N-1:0]     y = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] term_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dot_mac #(.N(N), .LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .term_cnt  (term_cnt)
    );

    task automatic drive(input int v, input int xv, input int yv, input int lv);
        in_valid = 1'(v);
        x        = N'(xv);
        y        = N'(yv);
        in_last  = 1'(lv);
    endtask

    // Called at the first negedge after the terminating edge; returns negedges until out_valid.
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || acc_out !== '0 || term_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b acc=%0d cnt=%0d, need 0 0 0 0",
                     in_ready, out_valid, acc_out, term_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, need 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_full;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            drive(1, 31, 31, (i == 3) ? 1 : 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || cyc != LAT) begin
            errors++;
            $display("FAIL full_latency: out_valid=%b cycles=%0d, need 1 and %0d", out_valid, cyc, LAT);
        end
        checks++;
        if (acc_out !== 12'd3844 || term_cnt !== 3'd4) begin
            errors++;
            $display("FAIL full_result: acc=%0d cnt=%0d, need 3844 4", acc_out, term_cnt);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_to_idle: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_short;
        int cyc;
        // Garbage on the bus with in_valid low must not start anything.
        drive(0, 31, 31, 1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ignore: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
        drive(1, 3, 4, 0);
        @(negedge clk);
        drive(1, 5, 6, 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || cyc != LAT || acc_out !== 12'd42 || term_cnt !== 3'd2) begin
            errors++;
            $display("FAIL short_result: valid=%b cycles=%0d acc=%0d cnt=%0d, need 1 %0d 42 2",
                     out_valid, cyc, acc_out, term_cnt, LAT);
        end
        consume();
    endtask

    task automatic test_single;
        int cyc;
        drive(1, 7, 9, 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || cyc != LAT || acc_out !== 12'd63 || term_cnt !== 3'd1) begin
            errors++;
            $display("FAIL single_result: valid=%b cycles=%0d acc=%0d cnt=%0d, need 1 %0d 63 1",
                     out_valid, cyc, acc_out, term_cnt, LAT);
        end
        consume();
    endtask

    task automatic test_len_cap;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 0);
            @(negedge clk);
        end
        drive(1, 1, 1, 0);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || cyc != LAT || acc_out !== 12'd4 || term_cnt !== 3'd4) begin
            errors++;
            $display("FAIL cap_result: valid=%b cycles=%0d acc=%0d cnt=%0d, need 1 %0d 4 4",
                     out_valid, cyc, acc_out, term_cnt, LAT);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL cap_ready_done: in_ready=%b, need 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || acc_out !== 12'd4 || term_cnt !== 3'd4) begin
            errors++;
            $display("FAIL cap_hold: valid=%b acc=%0d cnt=%0d, need 1 4 4", out_valid, acc_out, term_cnt);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || term_cnt !== 3'd4) begin
            errors++;
            $display("FAIL cap_release: valid=%b in_ready=%b cnt=%0d, need 0 1 4", out_valid, in_ready, term_cnt);
        end
        // Held fifth beat is taken now, then one more term closes the new sum: 1 + 2*3.
        @(negedge clk);
        drive(1, 2, 3, 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || acc_out !== 12'd7 || term_cnt !== 3'd2) begin
            errors++;
            $display("FAIL cap_new_sum: valid=%b acc=%0d cnt=%0d, need 1 7 2", out_valid, acc_out, term_cnt);
        end
        consume();
    endtask

    task automatic test_hold;
        int cyc;
        int bad;
        drive(1, 2, 3, 0);
        @(negedge clk);
        drive(1, 4, 5, 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        wait_out(cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            drive(i % 2, 31, 17, 1);
            checks++;
            if (out_valid !== 1'b1 || acc_out !== 12'd26 || term_cnt !== 3'd2 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b acc=%0d cnt=%0d in_ready=%b, need 1 26 2 0",
                         i, out_valid, acc_out, term_cnt, in_ready);
            end
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        drive(1, 2, 2, 0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || acc_out !== '0 || term_cnt !== '0) begin
            errors++;
            $display("FAIL midreset_clear: in_ready=%b valid=%b acc=%0d cnt=%0d, need 0 0 0 0",
                     in_ready, out_valid, acc_out, term_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 2, 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || cyc != LAT || acc_out !== 12'd2 || term_cnt !== 3'd1) begin
            errors++;
            $display("FAIL midreset_restart: valid=%b cycles=%0d acc=%0d cnt=%0d, need 1 %0d 2 1",
                     out_valid, cyc, acc_out, term_cnt, LAT);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_full();
        test_short();
        test_single();
        test_len_cap();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
